// File: rtl/butterfly_dmem.sv
// butterfly_dmem: single-port data memory responder with programmable wait states.
// Optional macro BUTTERFLY_DMEM_ERR_EN adds dmem_err_o for out-of-range accesses.
//
// state | meaning
// IDLE  | waiting for a request; latches it when dmem_valid_i=1
// WAIT  | counting down wait states; inputs ignored
// RESP  | one-cycle ready pulse carrying read data
module butterfly_dmem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dmem_valid_i,
  input  logic        dmem_we_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  input  logic [3:0]  dmem_wstrb_i,
  output logic [31:0] dmem_rdata_o,
  output logic        dmem_ready_o
`ifdef BUTTERFLY_DMEM_ERR_EN
  ,
  output logic        dmem_err_o
`endif
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               go_resp;
  logic               ready;

  logic               req_we_q;
  logic [IDX_W-1:0]   req_idx_q;
  logic [31:0]        req_wdata_q;
  logic [3:0]         req_wstrb_q;

  logic               in_idle;
  logic               capture;
  logic [IDX_W-1:0]   idx_in;
  logic               acc_we;
  logic [IDX_W-1:0]   acc_idx;
  logic [31:0]        acc_wdata;
  logic [3:0]         acc_wstrb;
  logic               acc_oor;
  logic               mem_we;

  logic [31:0]        mem [DEPTH_WORDS];

  assign in_idle = (state_q == IDLE);
  assign capture = in_idle && dmem_valid_i;
  assign idx_in  = IDX_W'((dmem_addr_i - BASE_ADDR) >> 2);

  // With zero wait states the access completes on the capture edge itself,
  // so the live inputs must feed the memory directly while in IDLE.
  assign acc_we    = in_idle ? dmem_we_i    : req_we_q;
  assign acc_idx   = in_idle ? idx_in       : req_idx_q;
  assign acc_wdata = in_idle ? dmem_wdata_i : req_wdata_q;
  assign acc_wstrb = in_idle ? dmem_wstrb_i : req_wstrb_q;

`ifdef BUTTERFLY_DMEM_ERR_EN
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

  logic oor_in;
  logic req_oor_q;

  assign oor_in  = (dmem_addr_i < BASE_ADDR) || ({1'b0, dmem_addr_i} >= END_ADDR);
  assign acc_oor = in_idle ? oor_in : req_oor_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_oor_q <= 1'b0;
    end else if (capture) begin
      req_oor_q <= oor_in;
    end
  end

  assign dmem_err_o = (state_q == RESP) && req_oor_q;
`else
  assign acc_oor = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_resp = 1'b0;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (dmem_valid_i) begin
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = RESP;
            go_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dmem_ready_o = ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_we_q    <= 1'b0;
      req_idx_q   <= '0;
      req_wdata_q <= 32'h0;
      req_wstrb_q <= 4'h0;
    end else if (capture) begin
      req_we_q    <= dmem_we_i;
      req_idx_q   <= idx_in;
      req_wdata_q <= dmem_wdata_i;
      req_wstrb_q <= dmem_wstrb_i;
    end
  end

  // Gating on rst_i keeps an aborted write from landing on the reset edge.
  assign mem_we = go_resp && acc_we && !acc_oor && !rst_i;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_wstrb[b]) begin
          mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dmem_rdata_o <= 32'h0;
    end else if (go_resp) begin
      dmem_rdata_o <= (acc_we || acc_oor) ? 32'h0 : mem[acc_idx];
    end
  end

endmodule

// File: tb/tb_butterfly_dmem.sv
// Directed bench for butterfly_dmem: one instance with no wait states, one with three.
module tb_butterfly_dmem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        err   [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  butterfly_dmem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0001_0000)) u_dut0 (
    .clk_i(clk), .rst_i(rst),
    .dmem_valid_i(valid[0]), .dmem_we_i(we[0]), .dmem_addr_i(addr[0]),
    .dmem_wdata_i(wdata[0]), .dmem_wstrb_i(wstrb[0]),
    .dmem_rdata_o(rdata[0]), .dmem_ready_o(ready[0])
`ifdef BUTTERFLY_DMEM_ERR_EN
    , .dmem_err_o(err[0])
`endif
  );

  butterfly_dmem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3), .BASE_ADDR(32'h0001_0000)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .dmem_valid_i(valid[1]), .dmem_we_i(we[1]), .dmem_addr_i(addr[1]),
    .dmem_wdata_i(wdata[1]), .dmem_wstrb_i(wstrb[1]),
    .dmem_rdata_o(rdata[1]), .dmem_ready_o(ready[1])
`ifdef BUTTERFLY_DMEM_ERR_EN
    , .dmem_err_o(err[1])
`endif
  );

`ifndef BUTTERFLY_DMEM_ERR_EN
  assign err[0] = 1'b0;
  assign err[1] = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete handshake; checks latency and that ready drops afterwards.
  task automatic access(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] s, input bit perturb,
                        output logic [31:0] rd, output logic er);
    int n;
    int exp_lat;
    exp_lat = (d == 0) ? 0 : 3;
    @(negedge clk);
    valid[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; wstrb[d] = s;
    @(posedge clk); #1;
    if (perturb) begin
      addr[d]  = a ^ 32'h4;
      wdata[d] = ~wd;
    end
    n = 0;
    while (!ready[d] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("latency_d%0d", d), 32'(n), 32'(exp_lat));
    rd = rdata[d];
    er = err[d];
    valid[d] = 1'b0;
    @(posedge clk); #1;
    check($sformatf("ready_pulse_d%0d", d), {31'b0, ready[d]}, 32'h0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          first_t, second_t, pulses;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0; wstrb[d] = 4'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready0", {31'b0, ready[0]}, 32'h0);
    check("rst_ready1", {31'b0, ready[1]}, 32'h0);
    check("rst_rdata0", rdata[0], 32'h0);
    check("rst_rdata1", rdata[1], 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // zero wait states: write then read back
    access(0, 1'b1, 32'h0001_0010, 32'hDEADBEEF, 4'hF, 1'b0, rd, er);
    check("w0_write_rdata", rd, 32'h0);
    access(0, 1'b0, 32'h0001_0010, 32'h0, 4'h0, 1'b0, rd, er);
    check("w0_read", rd, 32'hDEADBEEF);
    access(0, 1'b0, 32'h0001_0013, 32'h0, 4'hF, 1'b0, rd, er);
    check("w0_read_unaligned", rd, 32'hDEADBEEF);

    // partial writes on the three-wait-state instance
    access(1, 1'b1, 32'h0001_0030, 32'h11223344, 4'hF, 1'b0, rd, er);
    access(1, 1'b1, 32'h0001_0030, 32'hAABBCCDD, 4'b0101, 1'b0, rd, er);
    access(1, 1'b0, 32'h0001_0030, 32'h0, 4'h0, 1'b0, rd, er);
    check("partial_0101", rd, 32'h11BB33DD);
    access(1, 1'b1, 32'h0001_0030, 32'h55555555, 4'h0, 1'b0, rd, er);
    access(1, 1'b0, 32'h0001_0030, 32'h0, 4'h0, 1'b0, rd, er);
    check("partial_0000", rd, 32'h11BB33DD);
    access(1, 1'b1, 32'h0001_0030, 32'h0000_00EE, 4'b1000, 1'b0, rd, er);
    access(1, 1'b0, 32'h0001_0030, 32'h0, 4'h0, 1'b0, rd, er);
    check("partial_1000", rd, 32'h00BB33DD);

    // inputs changed during WAIT must not affect the latched access
    access(1, 1'b1, 32'h0001_0044, 32'h0, 4'hF, 1'b0, rd, er);
    access(1, 1'b1, 32'h0001_0040, 32'h12345678, 4'hF, 1'b1, rd, er);
    access(1, 1'b0, 32'h0001_0040, 32'h0, 4'h0, 1'b0, rd, er);
    check("latched_addr", rd, 32'h12345678);
    access(1, 1'b0, 32'h0001_0044, 32'h0, 4'h0, 1'b0, rd, er);
    check("ignored_addr", rd, 32'h0);

    // valid held high: ready at capture+3, next ready 5 cycles later
    @(negedge clk);
    valid[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0001_0040; wstrb[1] = 4'hF;
    first_t = -1; second_t = -1; pulses = 0;
    for (int t = 0; t < 12; t++) begin
      @(posedge clk); #1;
      if (ready[1]) begin
        pulses++;
        if (first_t < 0) first_t = t;
        else if (second_t < 0) second_t = t;
      end
      if (second_t >= 0) valid[1] = 1'b0;
    end
    valid[1] = 1'b0;
    repeat (8) @(posedge clk);
    check("held_first", 32'(first_t), 32'd3);
    check("held_second", 32'(second_t), 32'd8);
    check("held_pulses", 32'(pulses), 32'd2);

    // reset during WAIT of a write aborts it
    access(1, 1'b1, 32'h0001_0020, 32'h0, 4'hF, 1'b0, rd, er);
    @(negedge clk);
    valid[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h0001_0020; wdata[1] = 32'hA5A5A5A5; wstrb[1] = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_ready", {31'b0, ready[1]}, 32'h0);
    check("abort_state", 32'(u_dut1.state_q), 32'h0);
    @(negedge clk);
    valid[1] = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("abort_ready_hold", {31'b0, ready[1]}, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    access(1, 1'b0, 32'h0001_0020, 32'h0, 4'h0, 1'b0, rd, er);
    check("abort_readback", rd, 32'h0);

    // out-of-range write: flagged and suppressed, or aliased to word 0
    access(0, 1'b1, 32'h0001_0000, 32'hCAFEF00D, 4'hF, 1'b0, rd, er);
    access(0, 1'b1, 32'h0001_1000, 32'h0BADC0DE, 4'hF, 1'b0, rd, er);
`ifdef BUTTERFLY_DMEM_ERR_EN
    check("oor_write_err", {31'b0, er}, 32'h1);
    access(0, 1'b0, 32'h0001_0000, 32'h0, 4'h0, 1'b0, rd, er);
    check("oor_word0", rd, 32'hCAFEF00D);
    check("inrange_err", {31'b0, er}, 32'h0);
    access(0, 1'b0, 32'h0000_FFFC, 32'h0, 4'h0, 1'b0, rd, er);
    check("oor_read_data", rd, 32'h0);
    check("oor_read_err", {31'b0, er}, 32'h1);
`else
    access(0, 1'b0, 32'h0001_0000, 32'h0, 4'h0, 1'b0, rd, er);
    check("alias_word0", rd, 32'h0BADC0DE);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
